// File: rtl/ram_burst_master.sv
// Burst command sequencer for one port of a dual-port RAM: write bursts from a
// valid/ready stream, read bursts back out through a 2-entry skid FIFO.
// Optional: define RAM_BURST_STALL_CNT_EN to add the 16-bit stall_cnt output.
module ram_burst_master #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [ADDRESS_WIDTH:0]   cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     done,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
`ifdef RAM_BURST_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] cur;
  logic [ADDRESS_WIDTH:0]   rem;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    fifo [2];
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               fifo_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    din_q;
  logic                     accept, wr_fire, issue, pop, push;
  logic [2:0]               occ;

  always_comb begin
    cmd_ready = (state == S_IDLE) && !rst;
    accept    = cmd_valid && cmd_ready;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    wr_ready  = (state == S_WRITE) && (rem != '0) && !rst;
    wr_fire   = wr_valid && wr_ready;
    rd_valid  = (fifo_cnt != 2'd0);
    rd_data   = fifo[rd_ptr];
    pop       = rd_valid && rd_ready;
    push      = inflight;
    // A read may issue only if its data is sure to find a FIFO slot when it lands.
    occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
    issue     = !rst && (state == S_READ) && (rem != '0) && (occ < (3'd2 + {2'b00, pop}));
    ram_en    = wr_fire || issue;
    ram_we    = wr_fire;
    ram_addr  = ram_en ? cur : addr_q;
    ram_din   = wr_fire ? wr_data : din_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) begin
                 if (cmd_len == '0)  state_nxt = S_DONE;
                 else if (cmd_write) state_nxt = S_WRITE;
                 else                state_nxt = S_READ;
               end
      S_WRITE: if (wr_fire && rem == (ADDRESS_WIDTH+1)'(1)) state_nxt = S_DONE;
      S_READ:  if (rem == '0 && !inflight && fifo_cnt == 2'd1 && pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      rem      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      if (accept) begin
        cur <= cmd_addr;
        rem <= cmd_len;
      end else if (ram_en) begin
        cur <= cur + ADDRESS_WIDTH'(1);
        rem <= rem - (ADDRESS_WIDTH+1)'(1);
      end
      inflight <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if (ram_en)  addr_q <= cur;
      if (wr_fire) din_q  <= wr_data;
    end
  end

  // RAM data is valid the cycle after issue; capture it as it arrives.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo[wr_ptr] <= ram_dout;
  end

`ifdef RAM_BURST_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept)
      stall_cnt <= 16'd0;
    else if ((((state == S_READ) && rd_valid && !rd_ready) ||
              ((state == S_WRITE) && !wr_valid && rem != '0)) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: RAM behavioural model, transaction-level reference
// checked every cycle, plus directed literal checks and a random phase.
module tb_ram_burst_master;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, busy, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
`ifdef RAM_BURST_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int vec = 0;
  int err = 0;
  int cyc = 0;

  ram_burst_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_BURST_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM port: registered read, dout held when not reading.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_dout <= '0;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      else        ram_dout <= ram[ram_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else tick();
    end
    chk(nm, int'(seen), 1);
    tick();
  endtask

  // Reference: burst as counts of beats written, reads issued and beats popped.
  task automatic compare_loop();
    logic [DW-1:0] ref_mem [DEPTH];
    int iss_at [DEPTH];
    int mst = 0;  // 0 idle, 1 write, 2 read, 3 done
    int ma = 0, ml = 0, nb = 0, ni = 0, np = 0, stall_m = 0;
    logic [AW-1:0] ix;
    bit exp_valid, exp_en, pop;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_ram_en", int'(ram_en), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        mst = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        continue;
      end
      case (mst)
        0: begin
          chk("idle_busy", int'(busy), 0);
          chk("idle_done", int'(done), 0);
          chk("idle_cmd_ready", int'(cmd_ready), 1);
          chk("idle_wr_ready", int'(wr_ready), 0);
          chk("idle_rd_valid", int'(rd_valid), 0);
          chk("idle_ram_en", int'(ram_en), 0);
          if (cmd_valid) begin
            ma = int'(cmd_addr); ml = int'(cmd_len);
            nb = 0; ni = 0; np = 0; stall_m = 0;
            mst = (ml == 0) ? 3 : (cmd_write ? 1 : 2);
          end
        end
        3: begin
          chk("done_pulse", int'(done), 1);
          chk("done_busy", int'(busy), 1);
          chk("done_cmd_ready", int'(cmd_ready), 0);
          chk("done_ram_en", int'(ram_en), 0);
          chk("done_rd_valid", int'(rd_valid), 0);
`ifdef RAM_BURST_STALL_CNT_EN
          chk("done_stall_cnt", int'(stall_cnt), stall_m);
`endif
          mst = 0;
        end
        1: begin
          chk("wr_busy", int'(busy), 1);
          chk("wr_done", int'(done), 0);
          chk("wr_cmd_ready", int'(cmd_ready), 0);
          chk("wr_wr_ready", int'(wr_ready), 1);
          chk("wr_rd_valid", int'(rd_valid), 0);
          chk("wr_ram_en", int'(ram_en), int'(wr_valid));
          chk("wr_ram_we", int'(ram_we), int'(wr_valid));
          if (wr_valid) begin
            ix = AW'((ma + nb) % DEPTH);
            chk("wr_ram_addr", int'(ram_addr), int'(ix));
            chk("wr_ram_din", int'(ram_din), int'(wr_data));
            ref_mem[ix] = wr_data;
            nb++;
            if (nb == ml) mst = 3;
          end else begin
            stall_m++;
          end
        end
        default: begin
          chk("rd_busy", int'(busy), 1);
          chk("rd_done", int'(done), 0);
          chk("rd_wr_ready", int'(wr_ready), 0);
          chk("rd_ram_we", int'(ram_we), 0);
          exp_valid = (np < ni) && (iss_at[AW'(np)] + 2 <= cyc);
          chk("rd_valid", int'(rd_valid), int'(exp_valid));
          pop = exp_valid && rd_ready;
          exp_en = (ni < ml) && ((ni - np) - int'(pop) < 2);
          chk("rd_ram_en", int'(ram_en), int'(exp_en));
          if (exp_en) begin
            chk("rd_ram_addr", int'(ram_addr), (ma + ni) % DEPTH);
            iss_at[AW'(ni)] = cyc;
            ni++;
          end
          if (pop) begin
            ix = AW'((ma + np) % DEPTH);
            chk("rd_data", int'(rd_data), int'(ref_mem[ix]));
            np++;
            if (np == ml) mst = 3;
          end
          if (exp_valid && !rd_ready) stall_m++;
        end
      endcase
    end
  endtask

  initial begin
    logic [AW-1:0] lit_a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    int n, pops;
    bit seen;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    fork
      compare_loop();
    join_none
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ram_addr", int'(ram_addr), 0);
    chk("reset_ram_din", int'(ram_din), 0);
    chk("reset_busy", int'(busy), 0);

    // Write burst wrapping past the top of memory.
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd6; cmd_len = 4'd4;
    tick();
    cmd_valid = 0; wr_valid = 1; wr_data = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_wr_addr", int'(ram_addr), int'(lit_a[i]));
      chk("lit_wr_we", int'(ram_we), 1);
      tick();
      wr_data = 8'hA1 + 8'(i + 1);
    end
    wr_valid = 0;
    @(negedge clk);
    chk("lit_wr_done", int'(done), 1);
    tick();

    // Read it back at full rate: issue N..N+3, valid N+2..N+5, done N+6.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd6; cmd_len = 4'd4; rd_ready = 1;
    tick();
    cmd_valid = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("lit_rd_en", int'(ram_en), int'(c < 4));
      chk("lit_rd_valid", int'(rd_valid), int'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("lit_rd_data", int'(rd_data), 8'hA1 + c - 2);
      chk("lit_rd_done", int'(done), int'(c == 6));
      tick();
    end

    // Fill all 8 locations, then read back under backpressure.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd0; cmd_len = 4'd8;
    tick();
    cmd_valid = 0; wr_valid = 1; wr_data = 8'($urandom);
    repeat (8) begin
      tick();
      wr_data = 8'($urandom);
    end
    wr_valid = 0;
    tick();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd0; cmd_len = 4'd8; rd_ready = 0;
    tick();
    cmd_valid = 0; n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_en) n++;
      tick();
    end
    rd_ready = 1;
    chk("lit_bp_issued", n, 2);
    pops = 0; seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        if (rd_valid && rd_ready) pops++;
        tick();
      end
    end
    chk("lit_bp_done", int'(seen), 1);
    chk("lit_bp_pops", pops, 8);
    tick();

    // Zero-length command.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd3; cmd_len = 4'd0;
    @(negedge clk);
    chk("lit_len0_en_a", int'(ram_en), 0);
    tick();
    cmd_valid = 0;
    @(negedge clk);
    chk("lit_len0_done", int'(done), 1);
    chk("lit_len0_en_b", int'(ram_en), 0);
    tick();

    // Reset in the middle of a read burst after 3 beats.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd0; cmd_len = 4'd8; rd_ready = 1;
    tick();
    cmd_valid = 0; pops = 0;
    for (int k = 0; k < 40 && pops < 3; k++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) pops++;
      tick();
    end
    chk("lit_mid_pops", pops, 3);
    rst = 1; rd_ready = 0;
    @(negedge clk);
    chk("lit_rst_en", int'(ram_en), 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("lit_post_busy", int'(busy), 0);
    chk("lit_post_rd_valid", int'(rd_valid), 0);
    chk("lit_post_en", int'(ram_en), 0);
    chk("lit_post_done", int'(done), 0);
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd2; cmd_len = 4'd3;
    wr_valid = 1; wr_data = 8'h5C;
    tick();
    cmd_valid = 0;
    wait_done("lit_post_rst_burst");
    wr_valid = 0;

`ifdef RAM_BURST_STALL_CNT_EN
    // Three backpressured cycles with data waiting.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd2; cmd_len = 4'd4; rd_ready = 0;
    tick();
    cmd_valid = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rd_valid) seen = 1;
      else tick();
    end
    chk("lit_stall_valid", int'(seen), 1);
    repeat (3) tick();
    rd_ready = 1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      else tick();
    end
    chk("lit_stall_done", int'(seen), 1);
    chk("lit_stall_cnt", int'(stall_cnt), 3);
    tick();
`endif

    // Random traffic; the reference checks every cycle.
    for (int k = 0; k < 600; k++) begin
      tick();
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom_range(0, DEPTH - 1));
      cmd_len   = (AW+1)'($urandom_range(0, DEPTH));
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_data   = DW'($urandom);
      rd_ready  = ($urandom_range(0, 2) != 0);
    end
    tick();
    cmd_valid = 0; wr_valid = 1; rd_ready = 1;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (!busy) seen = 1;
      else tick();
    end
    chk("drain_idle", int'(seen), 1);
    wr_valid = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
